// File: rtl/gemm_systolic_stream_core.sv
// Streaming output-stationary GEMM core: skewed k-slice ingest, ROWSxCOLS MAC grid,
// optional accumulation across K chunks, and shift/relu/saturate row drain over valid/ready.
module gemm_systolic_stream_core #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned K_W    = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(ROWS+1)-1:0]    cfg_m,
  input  logic [$clog2(COLS+1)-1:0]    cfg_n,
  input  logic [K_W-1:0]               cfg_k,
  input  logic                         cfg_acc,
  input  logic                         cfg_last,
  input  logic [5:0]                   cfg_shift,
  input  logic                         cfg_relu,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_W-1:0]       in_a,
  input  logic [COLS*DATA_W-1:0]       in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic [COLS*OUT_W-1:0]        out_data
);
  localparam int unsigned M_W  = $clog2(ROWS+1);
  localparam int unsigned N_W  = $clog2(COLS+1);
  localparam int unsigned R_W  = $clog2(ROWS);
  localparam int unsigned FL_W = $clog2(ROWS+COLS);
  localparam int unsigned P_W  = 2*DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;
  logic [M_W-1:0]  m_q;
  logic [N_W-1:0]  n_q;
  logic [K_W-1:0]  k_q, beat_cnt;
  logic [FL_W-1:0] flush_cnt;
  logic            last_q, relu_q;
  logic [5:0]      shift_q;

  logic accept, row_acc, last_row;
  logic busy_nxt, done_nxt, in_ready_nxt, out_valid_nxt;
  logic clear_all, arr_valid, out_load;
  logic [R_W-1:0] out_sel;
  logic [COLS*OUT_W-1:0] post_row;

  logic signed [DATA_W-1:0] a_lane [ROWS];
  logic signed [DATA_W-1:0] b_lane [COLS];
  logic signed [DATA_W-1:0] a_arr  [ROWS];
  logic signed [DATA_W-1:0] b_arr  [COLS];
  logic signed [DATA_W-1:0] a_h    [ROWS][COLS-1];
  logic signed [DATA_W-1:0] b_v    [ROWS-1][COLS];
  logic signed [ACC_W-1:0]  acc_arr [ROWS][COLS];

  assign accept   = in_valid & in_ready;
  assign row_acc  = out_valid & out_ready;
  assign last_row = (out_row == R_W'(m_q - M_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_k == '0) ? S_FLUSH : S_LOAD;
      S_LOAD:  if (accept && beat_cnt == k_q - K_W'(1)) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == FL_W'(ROWS + COLS - 1))
                 state_nxt = (last_q && m_q != '0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (row_acc && last_row) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    in_ready_nxt  = (state_nxt == S_LOAD);
    out_valid_nxt = (state_nxt == S_DRAIN);
    clear_all     = (state == S_IDLE) && start && !cfg_acc;
    arr_valid     = (state == S_LOAD) || (state == S_FLUSH);
    out_load      = 1'b0;
    out_sel       = '0;
    if (state == S_FLUSH && state_nxt == S_DRAIN) begin
      out_load = 1'b1;
    end else if (state == S_DRAIN && row_acc && !last_row) begin
      out_load = 1'b1;
      out_sel  = R_W'(out_row + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0; n_q <= '0; k_q <= '0; last_q <= 1'b0; relu_q <= 1'b0; shift_q <= '0;
      beat_cnt <= '0; flush_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        m_q <= cfg_m; n_q <= cfg_n; k_q <= cfg_k; last_q <= cfg_last;
        relu_q <= cfg_relu; shift_q <= cfg_shift;
        beat_cnt <= '0; flush_cnt <= '0;
      end
      if (state == S_LOAD && accept) beat_cnt <= beat_cnt + K_W'(1);
      if (state == S_FLUSH) flush_cnt <= flush_cnt + FL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; done <= 1'b0; in_ready <= 1'b0; out_valid <= 1'b0;
      out_row <= '0; out_data <= '0;
    end else begin
      busy <= busy_nxt; done <= done_nxt; in_ready <= in_ready_nxt; out_valid <= out_valid_nxt;
      if (out_load) begin
        out_row  <= out_sel;
        out_data <= post_row;
      end
    end
  end

  // Masked lanes, then r/c-cycle skew so A[r][k] and B[k][c] meet at PE(r,c) at time k+r+c
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    assign a_lane[r] = (accept && M_W'(r) < m_q) ? in_a[r*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_pass
      assign a_arr[r] = a_lane[r];
    end else begin : g_sr
      logic signed [DATA_W-1:0] sr [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (arr_valid) begin
          sr[0] <= a_lane[r];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_arr[r] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    assign b_lane[c] = (accept && N_W'(c) < n_q) ? in_b[c*DATA_W +: DATA_W] : '0;
    if (c == 0) begin : g_pass
      assign b_arr[c] = b_lane[c];
    end else begin : g_sr
      logic signed [DATA_W-1:0] sr [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (arr_valid) begin
          sr[0] <= b_lane[c];
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_arr[c] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DATA_W-1:0] a_in, b_in, a_q, b_q;
      logic signed [P_W-1:0]    prod;
      logic signed [ACC_W-1:0]  acc_q;
      if (c == 0) begin : g_ain0
        assign a_in = a_arr[r];
      end else begin : g_ain
        assign a_in = a_h[r][c-1];
      end
      if (r == 0) begin : g_bin0
        assign b_in = b_arr[c];
      end else begin : g_bin
        assign b_in = b_v[r-1][c];
      end
      assign prod = P_W'(a_in) * P_W'(b_in);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0; a_q <= '0; b_q <= '0;
        end else begin
          if (clear_all)      acc_q <= '0;
          else if (arr_valid) acc_q <= acc_q + ACC_W'(prod);
          if (arr_valid) begin
            a_q <= a_in;
            b_q <= b_in;
          end
        end
      end
      assign acc_arr[r][c] = acc_q;
      if (c < COLS-1) begin : g_afwd
        assign a_h[r][c] = a_q;
      end
      if (r < ROWS-1) begin : g_bfwd
        assign b_v[r][c] = b_q;
      end
    end
  end

  function automatic logic [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] acc,
                                                 input logic [5:0] sh, input logic relu);
    logic signed [ACC_W-1:0] v;
    v = acc >>> sh;
    if (relu && v[ACC_W-1]) v = '0;
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return OUT_W'(v);
  endfunction

  // Row selected for the next out_data load; columns at or beyond cfg_n read as zero
  always_comb begin
    post_row = '0;
    for (int c = 0; c < COLS; c++) begin
      if (N_W'(c) < n_q) post_row[c*OUT_W +: OUT_W] = post_proc(acc_arr[out_sel][c], shift_q, relu_q);
    end
  end
endmodule

// File: tb/tb_gemm_systolic_stream_core.sv
// Randomized bench for gemm_systolic_stream_core (4x4) against a matrix-level reference model,
// run on an OUT_W=32 and an OUT_W=8 instance driven in lockstep.
module tb_gemm_systolic_stream_core;
  localparam int R = 4;
  localparam int C = 4;
  localparam int KMAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, cfg_acc, cfg_last, cfg_relu, in_valid, out_ready;
  logic [2:0] cfg_m, cfg_n;
  logic [11:0] cfg_k;
  logic [5:0] cfg_shift;
  logic [R*8-1:0] in_a;
  logic [C*8-1:0] in_b;
  logic busy, done, in_ready, out_valid;
  logic [1:0] out_row;
  logic [C*32-1:0] out_data;
  logic busy8, done8, in_ready8, out_valid8;
  logic [1:0] out_row8;
  logic [C*8-1:0] out_data8;

  gemm_systolic_stream_core #(.ROWS(R), .COLS(C), .DATA_W(8), .ACC_W(32), .OUT_W(32), .K_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .cfg_acc(cfg_acc), .cfg_last(cfg_last), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data));

  gemm_systolic_stream_core #(.ROWS(R), .COLS(C), .DATA_W(8), .ACC_W(32), .OUT_W(8), .K_W(12)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .cfg_acc(cfg_acc), .cfg_last(cfg_last), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .busy(busy8), .done(done8), .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid8), .out_ready(out_ready), .out_row(out_row8), .out_data(out_data8));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer matrices
  int cm [R][C];
  int a_m [R][KMAX];
  int b_m [KMAX][C];

  typedef struct packed {
    logic [1:0]   row;
    logic [127:0] d32;
    logic [31:0]  d8;
  } exp_t;
  exp_t expq[$];

  logic [127:0] got32 [R];
  logic [31:0]  got8  [R];

  function automatic longint post(input int acc, input int sh, input bit relu, input int w);
    longint v, mx, mn;
    v = longint'(acc) >>> sh;
    if (relu && v < 0) v = 0;
    mx = (longint'(1) <<< (w-1)) - 1;
    mn = -(longint'(1) <<< (w-1));
    if (v > mx) v = mx;
    if (v < mn) v = mn;
    return v;
  endfunction

  function automatic int rnd8();
    case ($urandom % 8)
      0: return -128;
      1: return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic fill_rand();
    for (int r = 0; r < R; r++) for (int k = 0; k < KMAX; k++) a_m[r][k] = rnd8();
    for (int k = 0; k < KMAX; k++) for (int c = 0; c < C; c++) b_m[k][c] = rnd8();
  endtask

  task automatic rand_cfg();
    cfg_m = 3'($urandom); cfg_n = 3'($urandom); cfg_k = 12'($urandom);
    cfg_acc = 1'($urandom); cfg_last = 1'($urandom); cfg_shift = 6'($urandom); cfg_relu = 1'($urandom);
  endtask

  // Output-side ready: optional 5-cycle stall on row 1, optional random backpressure
  bit rand_ready = 0;
  bit bp_mode = 0;
  int bp_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode && out_valid && out_row == 2'd1 && bp_cnt < 5) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = rand_ready ? ($urandom % 4 != 0) : 1'b1;
      end
    end
  end

  // Compare process: every accepted row against the model, plus hold-stability under stall
  bit held = 0;
  logic [1:0] hold_row;
  logic [127:0] hold_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held && out_valid) begin
        chk("hold_row", out_row, hold_row);
        chk("hold_data", out_data, hold_d);
      end
      held = out_valid && !out_ready;
      hold_row = out_row;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        chk("row_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("out_row", out_row, e.row);
          chk("out_data", out_data, e.d32);
          chk("valid8", out_valid8, 1);
          chk("out_row8", out_row8, e.row);
          chk("out_data8", out_data8, e.d8);
          got32[out_row] = out_data;
          got8[out_row] = out_data8;
        end
      end
    end
  end

  task automatic run_job(input int m, input int n, input int k, input bit acc, input bit last,
                         input int sh, input bit relu, input int gap, input bit poke);
    exp_t e;
    int idx, cyc;
    bit take;
    if (!acc) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cm[r][c] = 0;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        for (int kk = 0; kk < k; kk++) cm[r][c] += a_m[r][kk] * b_m[kk][c];
    if (last) begin
      for (int r = 0; r < m; r++) begin
        e = '0;
        e.row = 2'(r);
        for (int c = 0; c < n; c++) begin
          e.d32[c*32 +: 32] = 32'(post(cm[r][c], sh, relu, 32));
          e.d8[c*8 +: 8]    = 8'(post(cm[r][c], sh, relu, 8));
        end
        expq.push_back(e);
      end
    end
    @(posedge clk); #1;
    cfg_m = 3'(m); cfg_n = 3'(n); cfg_k = 12'(k); cfg_acc = acc; cfg_last = last;
    cfg_shift = 6'(sh); cfg_relu = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rand_cfg();
    chk("busy_after_start", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < k && cyc < 2000) begin
      take = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 3 != 2) : ($urandom % 3 != 0);
      in_valid = take;
      for (int r = 0; r < R; r++) in_a[r*8 +: 8] = (take && r < m) ? 8'(a_m[r][idx]) : 8'($urandom);
      for (int c = 0; c < C; c++) in_b[c*8 +: 8] = (take && c < n) ? 8'(b_m[idx][c]) : 8'($urandom);
      take = take && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    if (idx < k) chk("beat_timeout", idx, k);
    in_valid = 1'b0;
    in_a = R*8'($urandom);
    in_b = C*8'($urandom);
    chk("in_ready_after_load", in_ready, 0);
    if (poke) begin
      rand_cfg();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("done8_seen", done8, 1);
    chk("busy_at_done", busy, 1);
    chk("out_valid_at_done", out_valid, 0);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("busy_idle", busy, 0);
    chk("rows_left", expq.size(), 0);
    expq.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_data8"}, out_data8, 0);
  endtask

  task automatic clear_got();
    for (int r = 0; r < R; r++) begin got32[r] = '0; got8[r] = '0; end
  endtask

  task automatic post_case(input int a, input int b, input int sh, input bit relu);
    for (int r = 0; r < R; r++) for (int k = 0; k < KMAX; k++) a_m[r][k] = 0;
    for (int k = 0; k < KMAX; k++) for (int c = 0; c < C; c++) b_m[k][c] = 0;
    a_m[0][0] = a;
    b_m[0][0] = b;
    clear_got();
    run_job(1, 1, 1, 0, 1, sh, relu, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0; cfg_acc = 0; cfg_last = 0; cfg_shift = '0; cfg_relu = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cm[r][c] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Identity: A = I, B = [[1,2],[3,4]]
    for (int r = 0; r < R; r++) for (int k = 0; k < KMAX; k++) a_m[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < KMAX; k++) for (int c = 0; c < C; c++) b_m[k][c] = 0;
    b_m[0][0] = 1; b_m[0][1] = 2; b_m[1][0] = 3; b_m[1][1] = 4;
    clear_got();
    run_job(2, 2, 2, 0, 1, 0, 0, 0, 0);
    chk("ident_row0", got32[0], {32'd0, 32'd0, 32'd2, 32'd1});
    chk("ident_row1", got32[1], {32'd0, 32'd0, 32'd4, 32'd3});

    // Full 4x4, K=8, extremes, in_valid low every third cycle
    fill_rand();
    run_job(4, 4, 8, 0, 1, 0, 0, 1, 0);
    rand_ready = 1;
    fill_rand();
    run_job(4, 4, 8, 0, 1, 3, 1, 2, 0);
    rand_ready = 0;

    // K split: 4 + 2 chunks against the single-chunk K=6 sum held by the model
    begin
      int fa [R][6];
      int fb [6][C];
      fill_rand();
      for (int r = 0; r < R; r++) for (int k = 0; k < 6; k++) fa[r][k] = a_m[r][k];
      for (int k = 0; k < 6; k++) for (int c = 0; c < C; c++) fb[k][c] = b_m[k][c];
      run_job(4, 4, 4, 0, 0, 0, 0, 1, 0);
      for (int r = 0; r < R; r++) for (int k = 0; k < 2; k++) a_m[r][k] = fa[r][k+4];
      for (int k = 0; k < 2; k++) for (int c = 0; c < C; c++) b_m[k][c] = fb[k+4][c];
      run_job(4, 4, 2, 1, 1, 0, 0, 0, 0);
      for (int r = 0; r < R; r++) for (int k = 0; k < 6; k++) a_m[r][k] = fa[r][k];
      for (int k = 0; k < 6; k++) for (int c = 0; c < C; c++) b_m[k][c] = fb[k][c];
      run_job(4, 4, 6, 0, 1, 0, 0, 0, 0);
    end

    // Backpressure: out_ready low 5 cycles while row 1 is presented
    fill_rand();
    bp_mode = 1; bp_cnt = 0;
    run_job(4, 4, 3, 0, 1, 0, 0, 0, 0);
    bp_mode = 0;
    chk("bp_stall_cycles", bp_cnt, 5);

    // Post-processing corner values
    post_case(-100, 3, 2, 0);
    chk("post_shift32", got32[0], {96'd0, 32'hFFFF_FFB5});
    chk("post_shift8", got8[0], {24'd0, 8'hB5});
    post_case(-100, 3, 2, 1);
    chk("post_relu32", got32[0], 128'd0);
    post_case(100, 10, 0, 0);
    chk("post_pos32", got32[0], {96'd0, 32'd1000});
    chk("post_sat_hi8", got8[0], {24'd0, 8'h7F});
    post_case(-100, 10, 0, 0);
    chk("post_neg32", got32[0], {96'd0, 32'hFFFF_FC18});
    chk("post_sat_lo8", got8[0], {24'd0, 8'h80});

    // Start while busy is ignored
    fill_rand();
    run_job(3, 4, 5, 0, 1, 1, 0, 2, 1);

    // Reset mid-LOAD aborts; the following job is unaffected
    fill_rand();
    @(posedge clk); #1;
    cfg_m = 3'd4; cfg_n = 3'd4; cfg_k = 12'd8; cfg_acc = 0; cfg_last = 1; cfg_shift = '0; cfg_relu = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = R*8'($urandom);
    in_b = C*8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("midload_busy", busy, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    rst_n = 1'b1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cm[r][c] = 0;
    expq.delete();
    run_job(4, 4, 7, 1, 1, 0, 0, 1, 0);

    // Random jobs
    rand_ready = 1;
    for (int j = 0; j < 12; j++) begin
      int sh;
      fill_rand();
      sh = ($urandom % 5 == 0) ? 33 : int'($urandom_range(0, 8));
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
              1'($urandom), 1'($urandom), sh, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end
    rand_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
